// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed 7-segment driver with dead-time between digit slots.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic        frame_start,
  output logic        dig1,
  output logic        dig2,
  output logic        dig3,
  output logic        dig4,
  output logic        seg0,
  output logic        seg1,
  output logic        seg2,
  output logic        seg3,
  output logic        seg4,
  output logic        seg5,
  output logic        seg6,
  output logic        seg7
);

  // state | meaning
  // DEAD  | start of a slot, all digits and segments off (anti-ghosting gap)
  // ON    | digit idx enabled, segments from the active (frame-stable) regs

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } phase_t;

  phase_t       phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]   idx;
  logic         slot_end;

  logic [15:0]  shadow_val;
  logic [3:0]   shadow_dp;
  logic [3:0]   shadow_blank;
  logic [15:0]  act_val;
  logic [3:0]   act_dp;
  logic [3:0]   act_blank;

  logic [3:0]   dig_r;
  logic [7:0]   seg_r;

  logic [3:0]   nib;
  logic         dp_sel;
  logic         blank_sel;
  logic         lead_zero;
  logic [6:0]   glyph_n;
  logic [3:0]   dig_drive;
  logic [7:0]   seg_drive;

  // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    cnt_next  = slot_end ? '0 : cnt + 1'b1;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    lead_zero = 1'b0;
    case (idx)
      2'd0: begin
        nib       = act_val[15:12];
        dp_sel    = act_dp[3];
        blank_sel = act_blank[3];
        lead_zero = (act_val[15:12] == 4'h0);
      end
      2'd1: begin
        nib       = act_val[11:8];
        dp_sel    = act_dp[2];
        blank_sel = act_blank[2];
        lead_zero = (act_val[15:8] == 8'h00);
      end
      2'd2: begin
        nib       = act_val[7:4];
        dp_sel    = act_dp[1];
        blank_sel = act_blank[1];
        lead_zero = (act_val[15:4] == 12'h000);
      end
      default: begin
        nib       = act_val[3:0];
        dp_sel    = act_dp[0];
        blank_sel = act_blank[0];
        lead_zero = 1'b0;
      end
    endcase
    glyph_n = glyph(nib);
`ifdef SEVEN_SEG_LZB_EN
    if (lead_zero) glyph_n = 7'h7F;
`else
    if (lead_zero && 1'b0) glyph_n = 7'h7F;
`endif
    dig_drive      = 4'hF;
    dig_drive[idx] = 1'b0;
    seg_drive      = {~dp_sel, glyph_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= DEAD;
      cnt          <= '0;
      idx          <= 2'd0;
      shadow_val   <= 16'h0000;
      shadow_dp    <= 4'h0;
      shadow_blank <= 4'h0;
      act_val      <= 16'h0000;
      act_dp       <= 4'h0;
      act_blank    <= 4'h0;
      dig_r        <= 4'hF;
      seg_r        <= 8'hFF;
      frame_start  <= 1'b0;
    end else begin
      if (load) begin
        shadow_val   <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end
      cnt         <= cnt_next;
      phase       <= (cnt_next < CNT_DEAD) ? DEAD : ON;
      frame_start <= 1'b0;
      if (slot_end) begin
        idx <= idx + 2'd1;
        // Active regs only change at the frame boundary so a frame never tears.
        if (idx == 2'd3) begin
          act_val     <= shadow_val;
          act_dp      <= shadow_dp;
          act_blank   <= shadow_blank;
          frame_start <= 1'b1;
        end
      end
      if (phase == ON && !blank_sel) begin
        dig_r <= dig_drive;
        seg_r <= seg_drive;
      end else begin
        dig_r <= 4'hF;
        seg_r <= 8'hFF;
      end
    end
  end

  assign dig1 = dig_r[0];
  assign dig2 = dig_r[1];
  assign dig3 = dig_r[2];
  assign dig4 = dig_r[3];
  assign seg0 = seg_r[0];
  assign seg1 = seg_r[1];
  assign seg2 = seg_r[2];
  assign seg3 = seg_r[3];
  assign seg4 = seg_r[4];
  assign seg5 = seg_r[5];
  assign seg6 = seg_r[6];
  assign seg7 = seg_r[7];

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=8, DEAD_CYCLES=2.
// Segment bytes below are packed {seg7..seg0}; digit nibbles are {dig4..dig1}.
module tb_seven_seg_scan;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int FRAME = 4 * SD;

  localparam logic [7:0] G1 = 8'hF9;
  localparam logic [7:0] G2 = 8'hA4;
  localparam logic [7:0] G3 = 8'hB0;
  localparam logic [7:0] G4 = 8'h99;
  localparam logic [7:0] G5 = 8'h92;
  localparam logic [7:0] GA = 8'h88;
  localparam logic [7:0] G0 = 8'hC0;
  localparam logic [7:0] DARK = 8'hFF;
`ifdef SEVEN_SEG_LZB_EN
  localparam logic [7:0] ZL = 8'hFF;
`else
  localparam logic [7:0] ZL = 8'hC0;
`endif

  logic clk = 1'b0;
  logic rst, load;
  logic [15:0] value;
  logic [3:0] dp_in, blank_in;
  logic frame_start, dig1, dig2, dig3, dig4;
  logic seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [3:0] digs;
  logic [7:0] segs;
  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  seven_seg_scan #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .frame_start(frame_start),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  assign digs = {dig4, dig3, dig2, dig1};
  assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_dark(input string name);
    check({name, "_dig"}, 32'(digs), 32'hF);
    check({name, "_seg"}, 32'(segs), 32'hFF);
    check({name, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  task automatic wait_frame(input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!frame_start && cnt < budget);
    check("frame_start_seen", 32'(frame_start), 32'h1);
  endtask

  // Called right after a cycle where frame_start was observed; checks the next 32 cycles.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] blk,
                             input int load_at, input logic [15:0] lval);
    logic [7:0] es [4];
    logic [3:0] exp_dig;
    logic [7:0] exp_seg;
    int slot, pos;
    es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      load = 1'b0;
      if (k == load_at) begin
        load  = 1'b1;
        value = lval;
      end
      slot = (k - 1) / SD;
      pos  = (k - 1) % SD;
      exp_dig = 4'hF;
      exp_seg = DARK;
      if (pos >= DC && !blk[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_seg = es[slot];
      end
      check($sformatf("%s_k%0d_dig", tag, k), 32'(digs), 32'(exp_dig));
      check($sformatf("%s_k%0d_seg", tag, k), 32'(segs), 32'(exp_seg));
      check($sformatf("%s_k%0d_fs", tag, k), 32'(frame_start), 32'(k == FRAME));
    end
    load = 1'b0;
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v; dp_in = dp; blank_in = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
    repeat (3) begin
      step();
      check_dark("reset");
    end
    rst = 1'b0;
    step(); check_dark("rel1");
    step(); check_dark("rel2");
    step();
    check("first_dig1", 32'(digs), 32'hE);
    check("first_seg_zero", 32'(segs), 32'(ZL));
    check("first_fs", 32'(frame_start), 32'h0);
    load_once(16'h1234, 4'h0, 4'h0);
    wait_frame(40, n);
    check("first_frame_len", 32'(n + 4), 32'(FRAME));
    check_frame("v1234", G1, G2, G3, G4, 4'b0000, 0, 16'h0);

    load_once(16'h0004, 4'h0, 4'h0);
    wait_frame(40, n);
    check("frame_period", 32'(n + 1), 32'(FRAME));
    check_frame("v0004", ZL, ZL, ZL, G4, 4'b0000, 0, 16'h0);

    load_once(16'h1234, 4'b0001, 4'b0100);
    wait_frame(40, n);
    check_frame("blank_dp", G1, DARK, G3, 8'h19, 4'b0010, 0, 16'h0);

    load_once(16'h5555, 4'h0, 4'h0);
    wait_frame(40, n);
    check_frame("v5555_midload", G5, G5, G5, G5, 4'b0000, 12, 16'hAAAA);
    check_frame("vAAAA_wrapload", GA, GA, GA, GA, 4'b0000, 31, 16'h1234);
    check_frame("vAAAA_again", GA, GA, GA, GA, 4'b0000, 0, 16'h0);
    check_frame("v1234_late", G1, G2, G3, G4, 4'b0000, 0, 16'h0);

    repeat (20) step();
    check("pre_rst_dig3", 32'(digs), 32'hB);
    rst = 1'b1;
    step();
    check_dark("mid_rst");
    rst = 1'b0;
    step(); check_dark("rst_rel1");
    step(); check_dark("rst_rel2");
    step();
    check("rst_dig1", 32'(digs), 32'hE);
    check("rst_seg_zero", 32'(segs), 32'(ZL));
    wait_frame(40, n);
    check("rst_frame_len", 32'(n + 3), 32'(FRAME));
    check_frame("after_rst", ZL, ZL, ZL, G0, 4'b0000, 0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
